// File: rtl/rs_encoder_param_if.sv
// rs_encoder_param_if
//   Symbol-stream handshake bundle for rs_encoder_param.
//   Input side : din_val, din_sop, din -> encoder; din_rdy <- encoder.
//   Output side: dout_val, dout_sop, dout_eop, dout <- encoder; dout_rdy -> encoder.
//   frame_err  : one-cycle abort pulse from the encoder.
//   master = the side that feeds symbols in and sinks the codeword.
//   slave  = the encoder.
interface rs_encoder_param_if;
    logic       din_val;
    logic       din_sop;
    logic [7:0] din;
    logic       din_rdy;
    logic       dout_rdy;
    logic       dout_val;
    logic       dout_sop;
    logic       dout_eop;
    logic [7:0] dout;
    logic       frame_err;

    modport master (
        output din_val, din_sop, din, dout_rdy,
        input  din_rdy, dout_val, dout_sop, dout_eop, dout, frame_err
    );

    modport slave (
        input  din_val, din_sop, din, dout_rdy,
        output din_rdy, dout_val, dout_sop, dout_eop, dout, frame_err
    );
endinterface

// File: rtl/rs_encoder_param.sv
// rs_encoder_param
//   Systematic Reed-Solomon encoder over GF(256). Each frame of K information
//   symbols is passed through unchanged and followed by NSYM parity symbols,
//   highest-order first. The generator g(x) = prod (x + alpha^(FCR+i)),
//   alpha = 2, is expanded at elaboration time.
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : rs_encoder_param_if.slave
//            din_val/din_sop/din/din_rdy  : input symbol handshake
//            dout_val/dout_sop/dout_eop/dout/dout_rdy : codeword output handshake
//            frame_err : one-cycle pulse when a frame is aborted by a new sop
module rs_encoder_param #(
    parameter int         K         = 8,
    parameter int         NSYM      = 8,
    parameter logic [8:0] PRIM_POLY = 9'h11D,
    parameter int         FCR       = 0
) (
    input logic              clk,
    input logic              rst_n,
    rs_encoder_param_if.slave bus
);

    localparam int CW = $clog2(K + NSYM);
    localparam logic [CW-1:0] LAST_DATA = CW'(K - 1);
    localparam logic [CW-1:0] LAST_SYM  = CW'(K + NSYM - 1);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? PRIM_POLY[7:0] : 8'h00);
        end
        return acc;
    endfunction

    // Ascending coefficients of g(x); g[NSYM] is the implicit leading 1.
    function automatic logic [NSYM:0][7:0] gen_poly();
        logic [NSYM:0][7:0] g;
        logic [7:0]         root;
        g    = '0;
        g[0] = 8'h01;
        root = 8'h01;
        for (int unsigned i = 0; i < FCR; i++) root = gf_mul(root, 8'h02);
        for (int unsigned i = 0; i < NSYM; i++) begin
            for (int unsigned j = NSYM; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
            g[0] = gf_mul(g[0], root);
            root = gf_mul(root, 8'h02);
        end
        return g;
    endfunction

    localparam logic [NSYM:0][7:0] GEN = gen_poly();

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NSYM-1:0][7:0] lfsr_q, lfsr_d;
    logic [7:0]           dout_q, dout_d;
    logic                 dout_val_q, dout_val_d;
    logic                 dout_sop_q, dout_sop_d;
    logic                 dout_eop_q, dout_eop_d;
    logic                 frame_err_q, frame_err_d;
    logic                 ready_en_q, ready_en_d;

    logic                 out_free;
    logic                 din_rdy;
    logic                 in_xfer;
    logic [NSYM-1:0][7:0] lfsr_base;
    logic [NSYM-1:0][7:0] lfsr_next;
    logic [7:0]           fb;

    always_comb begin
        out_free = !dout_val_q || bus.dout_rdy;
        din_rdy  = (state_q != PARITY) && out_free && ready_en_q;
        in_xfer  = bus.din_val && din_rdy;

        // A sop symbol always starts from a cleared register, so the step
        // can be computed once for both the start and continue cases.
        lfsr_base = bus.din_sop ? '0 : lfsr_q;
        fb        = bus.din ^ lfsr_base[NSYM-1];
        lfsr_next = '0;
        lfsr_next[0] = gf_mul(fb, GEN[0]);
        for (int unsigned i = 1; i < NSYM; i++) begin
            lfsr_next[i] = lfsr_base[i-1] ^ gf_mul(fb, GEN[i]);
        end

        state_d     = state_q;
        cnt_d       = cnt_q;
        lfsr_d      = lfsr_q;
        dout_d      = dout_q;
        dout_val_d  = dout_val_q;
        dout_sop_d  = dout_sop_q;
        dout_eop_d  = dout_eop_q;
        frame_err_d = 1'b0;
        ready_en_d  = 1'b1;

        if (dout_val_q && bus.dout_rdy) begin
            dout_val_d = 1'b0;
            dout_sop_d = 1'b0;
            dout_eop_d = 1'b0;
        end

        if (state_q == PARITY) begin
            if (out_free) begin
                dout_d     = lfsr_q[NSYM-1];
                lfsr_d     = lfsr_q << 8;
                dout_val_d = 1'b1;
                dout_sop_d = 1'b0;
                dout_eop_d = (cnt_q == LAST_SYM);
                if (cnt_q == LAST_SYM) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end else if (in_xfer) begin
            if (bus.din_sop) begin
                // Start of frame; in DATA this also aborts the frame in flight.
                frame_err_d = (state_q == DATA);
                lfsr_d      = lfsr_next;
                dout_d      = bus.din;
                dout_val_d  = 1'b1;
                dout_sop_d  = 1'b1;
                dout_eop_d  = 1'b0;
                cnt_d       = CW'(1);
                state_d     = (K == 1) ? PARITY : DATA;
            end else if (state_q == DATA) begin
                lfsr_d     = lfsr_next;
                dout_d     = bus.din;
                dout_val_d = 1'b1;
                dout_sop_d = 1'b0;
                dout_eop_d = 1'b0;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == LAST_DATA) state_d = PARITY;
            end
            // Non-sop symbols accepted in IDLE are dropped.
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lfsr_q      <= '0;
            dout_q      <= '0;
            dout_val_q  <= 1'b0;
            dout_sop_q  <= 1'b0;
            dout_eop_q  <= 1'b0;
            frame_err_q <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            dout_q      <= dout_d;
            dout_val_q  <= dout_val_d;
            dout_sop_q  <= dout_sop_d;
            dout_eop_q  <= dout_eop_d;
            frame_err_q <= frame_err_d;
            ready_en_q  <= ready_en_d;
        end
    end

    assign bus.din_rdy   = din_rdy;
    assign bus.dout      = dout_q;
    assign bus.dout_val  = dout_val_q;
    assign bus.dout_sop  = dout_sop_q;
    assign bus.dout_eop  = dout_eop_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: doc/rs_encoder_param.md
RS_ENCODER_PARAM -- requirements
Module: rs_encoder_param

Interface
REQ-001 SHALL have parameter K, default 8: information symbols per frame (legal 1..253).
REQ-002 SHALL have parameter NSYM, default 8: parity symbols per frame, i.e. 2T (even, legal 2..32, K+NSYM <= 255).
REQ-003 SHALL have parameter PRIM_POLY, default 9'h11D: GF(256) field polynomial.
REQ-004 SHALL have parameter FCR, default 0: first consecutive root. The generator is g(x) = prod (x + alpha^(FCR+i)), i = 0..NSYM-1, with alpha = 2. Coefficients SHALL be derived at elaboration.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 din_val  input  1  input symbol valid.
REQ-008 din_sop  input  1  first information symbol of a frame; qualified by din_val.
REQ-009 din  input  8  information symbol.
REQ-010 din_rdy  output  1  encoder accepts din this cycle.
REQ-011 dout_rdy  input  1  downstream accepts dout this cycle.
REQ-012 dout_val  output  1  output symbol valid.
REQ-013 dout_sop  output  1  first codeword symbol.
REQ-014 dout_eop  output  1  last codeword symbol (last parity).
REQ-015 dout  output  8  codeword symbol.
REQ-016 frame_err  output  1  one-cycle pulse when a frame is aborted.

Function
REQ-017 Input transfer SHALL occur on din_val && din_rdy; output transfer SHALL occur on dout_val && dout_rdy.
REQ-018 The FSM SHALL have three states: IDLE, DATA and PARITY.
REQ-019 IDLE: an accepted symbol with din_sop SHALL become symbol 0, clear the LFSR and go to DATA; accepted symbols without din_sop SHALL be discarded.
REQ-020 DATA: each accepted symbol SHALL update the NSYM-stage systematic-division LFSR (feedback = din XOR top stage) and be passed to dout unchanged; after the K-th symbol the FSM SHALL go to PARITY.
REQ-021 PARITY: the FSM SHALL emit NSYM LFSR stages, highest-order first, one per free output slot, then return to IDLE.
REQ-022 din_rdy SHALL equal (state != PARITY) && (!dout_val || dout_rdy) && ready_en, where ready_en is a flop that resets to 0 and sets on the first clock after reset release.
REQ-023 Output SHALL be a single register stage: an accepted input appears on dout with dout_val=1 on the next cycle (latency 1).
REQ-024 While dout_val && !dout_rdy, dout, dout_sop and dout_eop SHALL hold stable, and no symbol is lost or duplicated.
REQ-025 dout_sop SHALL be 1 only on codeword symbol 0; dout_eop SHALL be 1 only on codeword symbol K+NSYM-1.
REQ-026 din_sop accepted in DATA SHALL abort the frame: pulse frame_err, clear the LFSR, restart counting with this symbol as symbol 0 and emit it with dout_sop=1; the aborted frame never gets dout_eop.
REQ-027 din_sop accepted in PARITY is impossible because din_rdy=0; din_val in PARITY SHALL be ignored.
REQ-028 With dout_rdy held at 1, din_rdy SHALL be low for exactly NSYM cycles per frame; the next frame may be accepted on the cycle after the last parity is loaded.
REQ-029 The symbol counter SHALL be ceil(log2(K+NSYM)) bits wide; GF multiplies SHALL be by constant coefficients and purely combinational.

Reset
REQ-030 When rst_n=0: dout_val, dout_sop, dout_eop, frame_err, din_rdy = 0; dout = 8'h00; LFSR = 0; counter = 0; state = IDLE; ready_en = 0.
REQ-031 Reset mid-frame (any state) SHALL discard the partial codeword; no dout_eop SHALL be produced for that frame.

Verification
REQ-032 For every captured codeword, the bench SHALL check that syndromes c(alpha^(FCR+j)), j = 0..NSYM-1, are all zero and that parity matches a software LFSR model.
REQ-033 Scenario 1 (defaults): reset for 2 cycles, then frame 0..7 with dout_rdy=1 -> dout 0..7 then 8 parity symbols; dout_sop on the first output (1 cycle after the first accept); dout_eop on the 16th; syndromes zero.
REQ-034 Scenario 2: all-zero frame -> 16 symbols of 8'h00, eop on the 16th.
REQ-035 Scenario 3: frame 0..7 with dout_rdy toggling 1,0,1,0... -> same 16 symbols as scenario 1; dout stable during stalls; din_rdy low whenever an output is stalled.
REQ-036 Scenario 4: sop at 0, three symbols, sop again, then 0..7 -> frame_err pulses once; exactly one eop; the final 16 symbols equal scenario 1.
REQ-037 Scenario 5: K=12, NSYM=4, two back-to-back frames 0..11 and 8'hFF x12 -> two 16-symbol codewords; din_rdy low exactly 4 cycles between frames; syndromes zero.
REQ-038 Scenario 6: rst_n pulsed low during PARITY of frame 0..7 -> outputs go to 0 immediately; the next frame encodes identically to scenario 1.
